tx_frame_builder: RTL and testbench
===================================

TX_FRAME_BUILDER -- requirements
Module: tx_frame_builder

Interface
REQ-001 Parameter TX_RX_M_AXIS_WIDTH, default 64, gives the data width; only 64 is supported.
REQ-002 Parameter MAX_FRAME_WORDS, default 256, sets the maximum payload words per frame; legal range 1..65535.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, sets the number of consecutive FIFO-empty cycles that closes a frame; legal range 1..65535.
REQ-004 TX_ACLK  in  1  single clock; all logic is posedge-triggered.
REQ-005 TX_ARESETN  in  1  asynchronous, active-low reset.
REQ-006 FIFO_DOUT  in  64  first-word-fall-through data from the serialized-data FIFO; valid whenever FIFO_EMPTY=0.
REQ-007 FIFO_EMPTY  in  1  serialized-data FIFO empty flag.
REQ-008 FIFO_RE  out  1  pop strobe; pops exactly one word per asserted cycle.
REQ-009 M_AXIS_TDATA  out  64  frame word toward the SFP transmitter.
REQ-010 M_AXIS_TVALID  out  1  frame word valid.
REQ-011 M_AXIS_TLAST  out  1  marks the footer word.
REQ-012 M_AXIS_TREADY  in  1  downstream accepts the word when it is high together with TVALID.
REQ-013 FRAME_BUSY  out  1  high in every state except IDLE.

Function
REQ-014 The output register forms a "slot". The slot is free when TVALID=0 or TREADY=1, and the register loads only when the slot is free.
REQ-015 If the slot is free and there is nothing to load, TVALID clears to 0. TDATA and TLAST hold their values while TVALID=1 and TREADY=0.
REQ-016 The FSM has four states: IDLE, HEADER, PAYLOAD, FOOTER.
REQ-017 IDLE goes to HEADER on the cycle after FIFO_EMPTY=0 is sampled; no FIFO pop occurs in IDLE.
REQ-018 HEADER: when the slot is free, load the header word and go to PAYLOAD.
  - Header layout: [63:56]=8'hA5, [55:40]=seq, [39:0]=0, TLAST=0.
REQ-019 PAYLOAD pop rule: FIFO_RE = (state==PAYLOAD) & slot free & !FIFO_EMPTY.
  - On each pop, load FIFO_DOUT with TLAST=0, increment the word count, and clear the idle counter.
REQ-020 PAYLOAD idle rule: on a cycle with state==PAYLOAD, FIFO_EMPTY=1 and the slot free, increment the idle counter. A cycle with the slot busy leaves the idle counter unchanged.
REQ-021 PAYLOAD goes to FOOTER when either:
  - the word count reaches MAX_FRAME_WORDS (counting the pop in that cycle), or
  - the idle counter reaches TIMEOUT_CYCLES.
  If both occur in the same cycle, MAX_FRAME_WORDS wins; the FOOTER is identical either way.
REQ-022 FOOTER: when the slot is free, load the footer word with TLAST=1.
  - Footer layout: [63:56]=8'h5A, [55:40]=word count, [39:32]=0, [31:0]=checksum.
  - After loading, increment seq (16-bit, wraps 16'hFFFF to 0), clear the word count, idle counter and checksum, and go to IDLE.
REQ-023 Every frame carries at least 1 payload word because HEADER is entered only with the FIFO non-empty. This block is the FIFO's only reader.
REQ-024 The word count is 16 bits and never exceeds MAX_FRAME_WORDS; the idle counter is 16 bits and saturates at TIMEOUT_CYCLES.
REQ-025 Back-to-back frames are allowed: IDLE goes straight back to HEADER if the FIFO is still non-empty.
REQ-026 Pass-through latency: a popped word appears on M_AXIS_TDATA the cycle after the FIFO_RE cycle.

Reset
REQ-027 While TX_ARESETN=0, all outputs and state reset asynchronously: state=IDLE, FIFO_RE=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, FRAME_BUSY=0, seq=0, word count=0, idle counter=0, checksum=0.
REQ-028 Reset asserted mid-frame abandons the frame; no footer is emitted. After release, the next frame starts with seq=0.
REQ-029 The block leaves IDLE no earlier than the first rising edge after TX_ARESETN deasserts.

Configuration
REQ-030 Macro FOOTER_CHECKSUM_EN controls the footer checksum.
  - Defined: checksum = sum modulo 2^32 of (word[63:32] + word[31:0]) over all payload words of the frame, accumulated at pop.
  - Undefined: footer [31:0]=32'h0 and no accumulator is synthesized.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
  - 3 words 1,2,3 preloaded, TREADY=1, TIMEOUT_CYCLES=16 -> output A5_0000_0000000000, 1, 2, 3, then footer 5A_0003_00_00000006 with TLAST=1; FIFO_RE pulses exactly 3 times.
  - MAX_FRAME_WORDS=4, 6 words queued -> frame 0 footer count 4; frame 1 header seq=1 with count 2 after timeout.
  - TREADY toggled 1/0 every cycle during payload -> TDATA stable while TVALID=1 and TREADY=0; no word lost or duplicated; FIFO_RE never high with the slot busy.
  - FIFO empties after 1 word and stays empty -> footer appears exactly after 16 empty slot-free cycles; a word arriving on empty cycle 10 resets the timeout.
  - TX_ARESETN pulsed low mid-payload -> TVALID=0 and FRAME_BUSY=0 immediately with no clock; the next header has seq=0.
  - Word 64'hFFFFFFFF_00000001 with FOOTER_CHECKSUM_EN defined -> checksum 32'h0; the same run without the macro -> footer [31:0]=0.

Source files
------------

// File: rtl/tx_frame_builder.sv
// Wraps words popped from a first-word-fall-through FIFO into header / payload / footer frames on an AXI-Stream master.
// Build option: define FOOTER_CHECKSUM_EN to carry a 32-bit payload checksum in the footer; otherwise the footer checksum field is zero.
module tx_frame_builder #(
  parameter int TX_RX_M_AXIS_WIDTH = 64,
  parameter int MAX_FRAME_WORDS    = 256,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                          TX_ACLK,
  input  logic                          TX_ARESETN,
  input  logic [TX_RX_M_AXIS_WIDTH-1:0] FIFO_DOUT,
  input  logic                          FIFO_EMPTY,
  output logic                          FIFO_RE,
  output logic [TX_RX_M_AXIS_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic                          FRAME_BUSY
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FOOTER} state_t;

  localparam logic [15:0] MAX_WORDS = 16'(MAX_FRAME_WORDS);
  localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_CYCLES);

  state_t                          state_q, state_d;
  logic [15:0]                     seq_q, seq_d;
  logic [15:0]                     wcnt_q, wcnt_d;
  logic [15:0]                     idle_q, idle_d;
  logic                            tvalid_q, tvalid_d;
  logic                            tlast_q, tlast_d;
  logic [TX_RX_M_AXIS_WIDTH-1:0]   tdata_q, tdata_d;
  logic                            busy_q, busy_d;
  logic                            slot_free;
  logic                            pop;
  logic                            load_footer;
  logic [31:0]                     checksum;

  // The output register is free when empty or being drained this cycle.
  assign slot_free   = !tvalid_q || M_AXIS_TREADY;
  assign pop         = (state_q == PAYLOAD) && slot_free && !FIFO_EMPTY;
  assign load_footer = (state_q == FOOTER) && slot_free;

`ifdef FOOTER_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (pop) begin
      cks_d = cks_q + FIFO_DOUT[63:32] + FIFO_DOUT[31:0];
    end else if (load_footer) begin
      cks_d = 32'h0;
    end
  end

  always_ff @(posedge TX_ACLK or negedge TX_ARESETN) begin
    if (!TX_ARESETN) begin
      cks_q <= 32'h0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = 32'h0;
`endif

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    wcnt_d   = wcnt_q;
    idle_d   = idle_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    if (slot_free) begin
      tvalid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (!FIFO_EMPTY) begin
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = {8'hA5, seq_q, 40'h0};
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pop) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = FIFO_DOUT;
          wcnt_d   = wcnt_q + 16'd1;
          idle_d   = 16'd0;
        end else if (slot_free && (idle_q != TIMEOUT)) begin
          idle_d = idle_q + 16'd1;
        end
        // A full frame and an expired timeout close the frame identically.
        if ((wcnt_d == MAX_WORDS) || (idle_d == TIMEOUT)) begin
          state_d = FOOTER;
        end
      end
      FOOTER: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tdata_d  = {8'h5A, wcnt_q, 8'h00, checksum};
          seq_d    = seq_q + 16'd1;
          wcnt_d   = 16'd0;
          idle_d   = 16'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge TX_ACLK or negedge TX_ARESETN) begin
    if (!TX_ARESETN) begin
      state_q  <= IDLE;
      seq_q    <= 16'd0;
      wcnt_q   <= 16'd0;
      idle_q   <= 16'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      wcnt_q   <= wcnt_d;
      idle_q   <= idle_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
    end
  end

  assign FIFO_RE       = pop;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign FRAME_BUSY    = busy_q;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Self-checking bench for tx_frame_builder: the bench acts as the FWFT FIFO and the stream sink,
// predicting the frame stream from bursts of words split into MAXW-sized frames.
module tb_tx_frame_builder;

  localparam int MAXW = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] fifo_dout = 64'h0;
  logic        fifo_empty = 1'b1;
  logic        fifo_re;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b1;
  logic        frame_busy;

  always #5 clk = ~clk;

  tx_frame_builder #(
    .TX_RX_M_AXIS_WIDTH(64),
    .MAX_FRAME_WORDS(MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .TX_ACLK(clk),
    .TX_ARESETN(rst_n),
    .FIFO_DOUT(fifo_dout),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_RE(fifo_re),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready),
    .FRAME_BUSY(frame_busy)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] fifo_q[$];
  logic [64:0] exp_q[$];
  logic [15:0] seq_m = 16'd0;

  int rdy_mode = 0;
  int cyc = 0;
  int re_count = 0;
  int last_re_cyc = 0;
  int first_beat_cyc = -1;
  int footer_cyc = 0;
  int frames_seen = 0;
  logic [63:0] last_footer = 64'h0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = 64'h0;
  logic        prev_last = 1'b0;

  typedef struct {
    int n;
    int mode;
    int exp_frames;
    int exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one frame = header(seq), the words, footer(count, checksum).
  task automatic add_frame(input logic [63:0] words[$]);
    logic [31:0] cks;
    cks = 32'h0;
    exp_q.push_back({1'b0, 8'hA5, seq_m, 40'h0});
    foreach (words[i]) begin
      exp_q.push_back({1'b0, words[i]});
      cks = cks + words[i][63:32] + words[i][31:0];
    end
`ifndef FOOTER_CHECKSUM_EN
    cks = 32'h0;
`endif
    exp_q.push_back({1'b1, 8'h5A, 16'(words.size()), 8'h00, cks});
    seq_m = seq_m + 16'd1;
  endtask

  // A burst queued all at once is cut into frames of at most MAXW words.
  task automatic add_burst(input int n, input logic [63:0] base, input bit rnd);
    logic [63:0] chunk[$];
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? {$urandom, $urandom} : base + 64'(i);
      fifo_q.push_back(w);
      chunk.push_back(w);
      if (chunk.size() == MAXW) begin
        add_frame(chunk);
        chunk.delete();
      end
    end
    if (chunk.size() > 0) add_frame(chunk);
  endtask

  task automatic cycle();
    logic re;
    logic [64:0] e;
    @(negedge clk);
    case (rdy_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      default: tready = ($urandom_range(0, 1) == 1);
    endcase
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 64'h0 : fifo_q[0];
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_valid", 64'(tvalid), 64'd1);
      check("hold_data", tdata, prev_data);
      check("hold_last", 64'(tlast), 64'(prev_last));
    end
    re = fifo_re;
    if (re) begin
      check("pop_rule", 64'(fifo_empty || (tvalid && !tready)), 64'd0);
      re_count++;
      last_re_cyc = cyc;
    end
    if (tvalid && !tlast) check("busy_in_frame", 64'(frame_busy), 64'd1);
    if (tvalid && tready) begin
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h last=%0d expected no beat", tdata, tlast);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", tdata, e[63:0]);
        check("beat_last", 64'(tlast), 64'(e[64]));
      end
      if (tlast) begin
        frames_seen++;
        footer_cyc  = cyc;
        last_footer = tdata;
      end
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    @(posedge clk);
    if (re && fifo_q.size() > 0) void'(fifo_q.pop_front());
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !frame_busy) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats still pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic clear_stats();
    re_count = 0;
    frames_seen = 0;
    first_beat_cyc = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int p;
    int n;
    logic [63:0] words[$];

    vecs[0] = '{n: 3, mode: 0, exp_frames: 1, exp_cnt: 3};
    vecs[1] = '{n: 6, mode: 0, exp_frames: 2, exp_cnt: 2};
    vecs[2] = '{n: 4, mode: 1, exp_frames: 1, exp_cnt: 4};
    vecs[3] = '{n: 8, mode: 2, exp_frames: 2, exp_cnt: 4};
    vecs[4] = '{n: 1, mode: 1, exp_frames: 1, exp_cnt: 1};
    vecs[5] = '{n: 9, mode: 2, exp_frames: 3, exp_cnt: 1};
    vecs[6] = '{n: 5, mode: 1, exp_frames: 2, exp_cnt: 1};

    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", tdata, 64'h0);
    check("rst_busy", 64'(frame_busy), 64'd0);
    check("rst_re", 64'(fifo_re), 64'd0);
    #11 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Words 1,2,3 preloaded: header, payload, timeout footer.
    rdy_mode = 0;
    clear_stats();
    add_burst(3, 64'd1, 1'b0);
    c0 = cyc + 1;
    wait_done("basic", 400);
    check("basic_frames", 64'(frames_seen), 64'd1);
    check("basic_pops", 64'(re_count), 64'd3);
    check("basic_hdr_lat", 64'(first_beat_cyc - c0), 64'd2);
    check("basic_tmo_lat", 64'(footer_cyc - last_re_cyc), 64'd18);
`ifdef FOOTER_CHECKSUM_EN
    check("basic_footer", last_footer, 64'h5A00_0300_0000_0006);
`else
    check("basic_footer", last_footer, 64'h5A00_0300_0000_0000);
`endif

    for (int v = 0; v < 7; v++) begin
      rdy_mode = vecs[v].mode;
      clear_stats();
      add_burst(vecs[v].n, 64'h100 * 64'(v + 1), 1'b0);
      wait_done("vec", 600);
      check("vec_frames", 64'(frames_seen), 64'(vecs[v].exp_frames));
      check("vec_last_cnt", 64'(last_footer[55:40]), 64'(vecs[v].exp_cnt));
      check("vec_pops", 64'(re_count), 64'(vecs[v].n));
    end

    // A word arriving on the 10th empty cycle restarts the timeout.
    rdy_mode = 0;
    clear_stats();
    words.delete();
    words.push_back(64'hAAAA_0000_0000_0001);
    words.push_back(64'hAAAA_0000_0000_0002);
    add_frame(words);
    fifo_q.push_back(words[0]);
    n = 0;
    while (re_count == 0 && n < 50) begin
      cycle();
      n++;
    end
    check("tmo_first_pop", 64'(re_count), 64'd1);
    p = last_re_cyc;
    for (int i = 0; i < 9; i++) cycle();
    fifo_q.push_back(words[1]);
    cycle();
    check("tmo_second_pop_cyc", 64'(last_re_cyc - p), 64'd10);
    check("tmo_no_early_footer", 64'(frames_seen), 64'd0);
    wait_done("tmo", 400);
    check("tmo_footer_lat", 64'(footer_cyc - last_re_cyc), 64'd18);
    check("tmo_frames", 64'(frames_seen), 64'd1);

    // Checksum wrap: the word halves sum to 2^32.
    clear_stats();
    words.delete();
    words.push_back(64'hFFFF_FFFF_0000_0001);
    add_frame(words);
    fifo_q.push_back(words[0]);
    wait_done("cks", 400);
    check("cks_wrap", 64'(last_footer[31:0]), 64'h0);
    check("cks_count", 64'(last_footer[55:40]), 64'd1);

    // Randomized bursts against the model.
    for (int r = 0; r < 15; r++) begin
      rdy_mode = int'($urandom_range(0, 2));
      for (int g = 0; g < int'($urandom_range(0, 5)); g++) cycle();
      clear_stats();
      n = int'($urandom_range(1, 10));
      add_burst(n, 64'h0, 1'b1);
      wait_done("rand", 800);
      check("rand_pops", 64'(re_count), 64'(n));
    end

    // Reset mid-payload abandons the frame and restarts seq at 0.
    rdy_mode = 0;
    clear_stats();
    add_burst(4, 64'h7700, 1'b0);
    n = 0;
    while (re_count < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("rst_mid_pops", 64'(re_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(tvalid), 64'd0);
    check("rst_mid_busy", 64'(frame_busy), 64'd0);
    check("rst_mid_tlast", 64'(tlast), 64'd0);
    check("rst_mid_re", 64'(fifo_re), 64'd0);
    exp_q.delete();
    fifo_q.delete();
    seq_m = 16'd0;
    prev_stall = 1'b0;
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    clear_stats();
    add_burst(2, 64'h8800, 1'b0);
    wait_done("post_rst", 400);
    check("post_rst_frames", 64'(frames_seen), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
